// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the I2S receiver:
//   SAMPLE_WIDTH  width of one delivered audio sample
//   rx_state_e    receiver framing FSM states
//   sat_inc8      8-bit saturating increment used by the optional drop counter
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } rx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/i2s_sync.sv
// -----------------------------------------------------------------------------
// i2s_sync
// Two-flop synchronizer for one asynchronous input, plus an extra history flop
// for edge detection in the clk domain.
//   clk     system clock
//   reset   asynchronous active-low reset (all flops cleared)
//   d_i     asynchronous input
//   q_o     synchronized level
//   rise_o  synchronized level is 1 and was 0 in the previous clk cycle
//   edge_o  synchronized level differs from the previous clk cycle
// -----------------------------------------------------------------------------
module i2s_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one-cycle history of the synchronized level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign edge_o = sync_q ^ prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
// Oversampling I2S receiver: SCLK/LRCLK/SDATA are synchronized into clk and
// sampled on detected SCLK rising edges. The first 16 bits of each slot (MSB
// first, after the I2S one-bit delay) are delivered to a one-entry
// valid/ready register per channel.
//   bits_per_slot  SCLK cycles per LRCLK half-frame (16..32); slots are framed
//                  by LRCLK changes, so bits past 16 are simply ignored
//   clk, reset     system clock, asynchronous active-low reset
//   i_sclk, i_lrclk, i_sdata   asynchronous I2S pins (lrclk 0 = left)
//   o_left_*/o_right_*         per-channel valid/ready(input)/value
//   o_overflow     one-cycle pulse per sample dropped on a full channel
//   o_drop_count   (only with I2S_RX_DROP_COUNT_EN) saturating count of
//                  overflows and short (<16-bit) slots
// -----------------------------------------------------------------------------
module i2s_receiver
    import audio_pkg::*;
#(
    parameter int unsigned bits_per_slot = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_sclk,
    input  logic                    i_lrclk,
    input  logic                    i_sdata,
    output logic                    o_left_valid,
    input  logic                    o_left_ready,
    output logic [SAMPLE_WIDTH-1:0] o_left_value,
    output logic                    o_right_valid,
    input  logic                    o_right_ready,
    output logic [SAMPLE_WIDTH-1:0] o_right_value,
    output logic                    o_overflow
`ifdef I2S_RX_DROP_COUNT_EN
    ,
    output logic [7:0]              o_drop_count
`endif
);

    logic sclk_s, sclk_rise_s, sclk_edge_s;
    logic lr_s, lr_rise_s, lr_edge_s;
    logic sdata_s, sdata_rise_s, sdata_edge_s;

    i2s_sync u_sync_sclk  (.clk(clk), .reset(reset), .d_i(i_sclk),
                           .q_o(sclk_s), .rise_o(sclk_rise_s), .edge_o(sclk_edge_s));
    i2s_sync u_sync_lrclk (.clk(clk), .reset(reset), .d_i(i_lrclk),
                           .q_o(lr_s), .rise_o(lr_rise_s), .edge_o(lr_edge_s));
    i2s_sync u_sync_sdata (.clk(clk), .reset(reset), .d_i(i_sdata),
                           .q_o(sdata_s), .rise_o(sdata_rise_s), .edge_o(sdata_edge_s));

    rx_state_e                 state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-2:0]   shift_q, shift_d;
    logic                      chan_q, chan_d;
    logic                      lr_prev_q;
    logic                      primed_q;
    logic                      left_valid_q, left_valid_d;
    logic [SAMPLE_WIDTH-1:0]   left_value_q, left_value_d;
    logic                      right_valid_q, right_valid_d;
    logic [SAMPLE_WIDTH-1:0]   right_value_q, right_value_d;
    logic                      overflow_q;
    logic                      lr_change_s, deliver_s, short_s, l_ovf_s, r_ovf_s;
    logic [SAMPLE_WIDTH-1:0]   word_s;

    // The first SCLK edge after reset only records LRCLK, so a slot already in
    // progress at reset release is never mistaken for a fresh boundary.
    assign lr_change_s = sclk_rise_s & primed_q & (lr_s != lr_prev_q);
    assign word_s      = {shift_q, sdata_s};

    // Framing FSM: the bit sampled on an edge belongs to the current slot, and
    // an LRCLK change seen on that same edge starts the next slot afterwards.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        chan_d    = chan_q;
        deliver_s = 1'b0;
        short_s   = 1'b0;
        if (sclk_rise_s) begin
            case (state_q)
                SYNC: begin
                    if (lr_change_s) begin
                        chan_d  = lr_s;
                        cnt_d   = 4'd0;
                        state_d = SHIFT;
                    end else begin
                        state_d = SYNC;
                    end
                end
                SHIFT: begin
                    shift_d = {shift_q[SAMPLE_WIDTH-3:0], sdata_s};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        deliver_s = 1'b1;
                        state_d   = WAIT;
                    end else begin
                        state_d   = SHIFT;
                    end
                    if (lr_change_s) begin
                        short_s = (cnt_q != 4'd15);
                        chan_d  = lr_s;
                        cnt_d   = 4'd0;
                        state_d = SHIFT;
                    end else begin
                        chan_d  = chan_q;
                    end
                end
                WAIT: begin
                    if (lr_change_s) begin
                        chan_d  = lr_s;
                        cnt_d   = 4'd0;
                        state_d = SHIFT;
                    end else begin
                        state_d = WAIT;
                    end
                end
                default: begin
                    state_d = SYNC;
                    cnt_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Left output register: a delivery onto a stalled full entry is dropped;
    // a delivery coinciding with a transfer simply replaces the entry.
    always_comb begin
        left_valid_d = left_valid_q;
        left_value_d = left_value_q;
        l_ovf_s      = 1'b0;
        if (deliver_s && !chan_q) begin
            if (left_valid_q && !o_left_ready) begin
                l_ovf_s = 1'b1;
            end else begin
                left_valid_d = 1'b1;
                left_value_d = word_s;
            end
        end else if (left_valid_q && o_left_ready) begin
            left_valid_d = 1'b0;
        end else begin
            left_valid_d = left_valid_q;
        end
    end

    // Right output register, identical handshake to the left one.
    always_comb begin
        right_valid_d = right_valid_q;
        right_value_d = right_value_q;
        r_ovf_s       = 1'b0;
        if (deliver_s && chan_q) begin
            if (right_valid_q && !o_right_ready) begin
                r_ovf_s = 1'b1;
            end else begin
                right_valid_d = 1'b1;
                right_value_d = word_s;
            end
        end else if (right_valid_q && o_right_ready) begin
            right_valid_d = 1'b0;
        end else begin
            right_valid_d = right_valid_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SYNC;
            cnt_q         <= 4'd0;
            shift_q       <= '0;
            chan_q        <= 1'b0;
            lr_prev_q     <= 1'b0;
            primed_q      <= 1'b0;
            left_valid_q  <= 1'b0;
            left_value_q  <= '0;
            right_valid_q <= 1'b0;
            right_value_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            chan_q        <= chan_d;
            if (sclk_rise_s) begin
                lr_prev_q <= lr_s;
                primed_q  <= 1'b1;
            end
            left_valid_q  <= left_valid_d;
            left_value_q  <= left_value_d;
            right_valid_q <= right_valid_d;
            right_value_q <= right_value_d;
            overflow_q    <= l_ovf_s | r_ovf_s;
        end
    end

`ifdef I2S_RX_DROP_COUNT_EN
    logic [7:0] drop_q;

    // Saturating count of overflowed samples and short slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= 8'd0;
        end else if (l_ovf_s || r_ovf_s || short_s) begin
            drop_q <= sat_inc8(drop_q);
        end
    end

    assign o_drop_count = drop_q;
`endif

    assign o_left_valid  = left_valid_q;
    assign o_left_value  = left_value_q;
    assign o_right_valid = right_valid_q;
    assign o_right_value = right_value_q;
    assign o_overflow    = overflow_q;

endmodule
